wishbone_ram_slave: RTL

- Wishbone B4 classic-cycle responder backing a word-organised RAM.
- Terminates either CPU bus: the instruction-fetch master or the load/store master.
- Supports byte-lane writes, a configurable number of wait states and a base-address window.
- Gives the bench and SoC top a memory with realistic handshake latency, so fetch and LSU stalls are exercised.

---
 rtl/wishbone_pkg.sv | 26 ++
 rtl/wishbone_if.sv | 25 ++
 rtl/sp_ram_be.sv | 52 +++++
 rtl/wishbone_ram_slave.sv | 138 +++++++++++++
 4 files changed

// File: rtl/wishbone_pkg.sv
// Shared Wishbone slave definitions: FSM state encoding, bus widths and the
// byte-lane merge helper used by the RAM.
package wishbone_pkg;

   localparam int WB_SEL_W  = 4;
   localparam int WB_DATA_W = 32;

   typedef enum logic [1:0] {
      WB_IDLE = 2'd0,
      WB_WAIT = 2'd1,
      WB_ACK  = 2'd2
   } wb_slave_state_t;

   function automatic logic [WB_DATA_W-1:0] wb_byte_merge(
      input logic [WB_DATA_W-1:0] old_word,
      input logic [WB_DATA_W-1:0] new_word,
      input logic [WB_SEL_W-1:0]  sel
   );
      logic [WB_DATA_W-1:0] merged;
      for (int i = 0; i < WB_SEL_W; i++) begin
         merged[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/wishbone_if.sv
// Wishbone B4 classic-cycle signal bundle with master and slave views.
interface wishbone_if;
   import wishbone_pkg::*;

   logic                 cyc;
   logic                 stb;
   logic                 we;
   logic [WB_SEL_W-1:0]  sel;
   logic [31:0]          adr;
   logic [WB_DATA_W-1:0] dat_w;
   logic [WB_DATA_W-1:0] dat_r;
   logic                 ack;
   logic                 err;

   modport master (
      output cyc, stb, we, sel, adr, dat_w,
      input  dat_r, ack, err
   );

   modport slave (
      input  cyc, stb, we, sel, adr, dat_w,
      output dat_r, ack, err
   );

endinterface

// File: rtl/sp_ram_be.sv
// Single-port synchronous RAM, 32-bit words with four byte enables and a
// registered read port; contents start zero-filled.
module sp_ram_be
   import wishbone_pkg::*;
#(
   parameter int DEPTH     = 4096,
   parameter     INIT_FILE = ""
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     we,
   input  logic                     clr,
   input  logic [WB_SEL_W-1:0]      be,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WB_DATA_W-1:0]     wdata,
   output logic [WB_DATA_W-1:0]     rdata
);

   logic [WB_DATA_W-1:0] mem [DEPTH];
   logic [WB_DATA_W-1:0] rdata_d, rdata_q;

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   end

   // NOTE: the storage array has no reset branch; only the read register is
   // reset, so the array maps onto block RAM and survives a bus reset.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem[addr] <= wb_byte_merge(mem[addr], wdata, be);
      end
   end

   // Read data only moves on a read or a clear, so it stays stable across writes.
   always_comb begin
      rdata_d = rdata_q;
      if (clr) begin
         rdata_d = '0;
      end else if (en && !we) begin
         rdata_d = mem[addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/wishbone_ram_slave.sv
// Wishbone B4 classic slave in front of a byte-writable RAM, with programmable
// wait states. Define WB_RAM_RANGE_ERR_EN to answer out-of-window addresses with err.
module wishbone_ram_slave
   import wishbone_pkg::*;
#(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0,
   parameter              INIT_FILE   = ""
) (
   input logic       clk,
   input logic       reset,
   wishbone_if.slave wishbone_bus
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   localparam logic [1:0] ST_IDLE = WB_IDLE;
   localparam logic [1:0] ST_WAIT = WB_WAIT;
   localparam logic [1:0] ST_ACK  = WB_ACK;

   logic [1:0]           state_d,   state_q;
   logic [3:0]           cnt_d,     cnt_q;
   logic                 req_we_d,  req_we_q;
   logic                 req_err_d, req_err_q;
   logic [WB_SEL_W-1:0]  req_sel_d, req_sel_q;
   logic [AW-1:0]        req_idx_d, req_idx_q;
   logic [WB_DATA_W-1:0] req_dat_d, req_dat_q;

   logic [31:0]          bus_off;
   logic [AW-1:0]        bus_idx;
   logic                 bus_err;
   logic                 go_ack;
   logic                 ram_en;
   logic                 ram_clr;
   logic [WB_DATA_W-1:0] ram_rdata;

   // Offset wraps for addresses below the base, so one compare covers both ends.
   assign bus_off = wishbone_bus.adr - BASE_ADDR;
   assign bus_idx = bus_off[AW+1:2];
`ifdef WB_RAM_RANGE_ERR_EN
   assign bus_err = ({1'b0, bus_off} >= SPAN);
`else
   assign bus_err = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_we_d  = req_we_q;
      req_err_d = req_err_q;
      req_sel_d = req_sel_q;
      req_idx_d = req_idx_q;
      req_dat_d = req_dat_q;
      go_ack    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wishbone_bus.cyc && wishbone_bus.stb) begin
               req_we_d  = wishbone_bus.we;
               req_err_d = bus_err;
               req_sel_d = wishbone_bus.sel;
               req_idx_d = bus_idx;
               req_dat_d = wishbone_bus.dat_w;
               if (WAIT_STATES == 0) begin
                  state_d = ST_ACK;
                  go_ack  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (!wishbone_bus.cyc) begin
               state_d = ST_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = ST_ACK;
               go_ack  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         req_we_q  <= 1'b0;
         req_err_q <= 1'b0;
         req_sel_q <= '0;
         req_idx_q <= '0;
         req_dat_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_we_q  <= req_we_d;
         req_err_q <= req_err_d;
         req_sel_q <= req_sel_d;
         req_idx_q <= req_idx_d;
         req_dat_q <= req_dat_d;
      end
   end

   // The *_d request fields equal the live bus in IDLE and the capture in WAIT,
   // so the RAM access lands exactly on the edge entering ACK.
   assign ram_en  = go_ack && !req_err_d && !reset;
   assign ram_clr = go_ack && req_err_d;

   sp_ram_be #(
      .DEPTH     (DEPTH_WORDS),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk   (clk),
      .rst   (reset),
      .en    (ram_en),
      .we    (req_we_d),
      .clr   (ram_clr),
      .be    (req_sel_d),
      .addr  (req_idx_d),
      .wdata (req_dat_d),
      .rdata (ram_rdata)
   );

   assign wishbone_bus.dat_r = ram_rdata;
   assign wishbone_bus.ack   = (state_q == ST_ACK) && !req_err_q;
`ifdef WB_RAM_RANGE_ERR_EN
   assign wishbone_bus.err   = (state_q == ST_ACK) && req_err_q;
`else
   assign wishbone_bus.err   = 1'b0;
`endif

endmodule
